// File: rtl/rom_cache_pkg.sv
// Shared definitions for the ROM fetch cache: FSM state encoding and
// index/tag width derivation from the line count.
package rom_cache_pkg;

  localparam int unsigned ADDR_W = 32'd24;
  localparam int unsigned DATA_W = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FILL     = 2'd1,
    ST_PREFETCH = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      if ((64'd1 << i) < {32'd0, v}) begin
        r = i + 32'd1;
      end
    end
    return r;
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return clog2(lines);
  endfunction

  // Word offset takes two address bits, the index takes the next idx_w bits.
  function automatic int unsigned tag_w(input int unsigned lines);
    return ADDR_W - 32'd2 - clog2(lines);
  endfunction

endpackage

// File: rtl/rom_cache_lines.sv
// Line storage for the ROM fetch cache: valid/tag/data arrays with one write
// port, one combinational read port and a single-cycle invalidate of all lines.
module rom_cache_lines
  import rom_cache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDX_W = idx_w(LINES),
  parameter int unsigned TAG_W = tag_w(LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  // Flush wins over a coincident write so a fill racing a flush never lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/rom_fetch_cache.sv
// Direct-mapped, one-word-per-line read cache between the CPU memory port and the ROM reader.
// Define ROM_PREFETCH_EN to fetch the next word into the cache after every fill.
module rom_fetch_cache
  import rom_cache_pkg::*;
#(
  parameter int unsigned LINES    = 16,
  parameter logic [23:0] WIN_BASE = 24'h100000,
  parameter int unsigned WIN_SIZE = 8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [23:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        rom_valid,
  output logic [23:0] rom_addr,
  input  logic        rom_ready,
  input  logic [31:0] rom_rdata
);

  localparam int unsigned IDX_W  = idx_w(LINES);
  localparam int unsigned TAG_W  = tag_w(LINES);
  // One extra bit so the window end never wraps at the top of the 24-bit space.
  localparam logic [24:0] WIN_LO = {1'b0, WIN_BASE};
  localparam logic [24:0] WIN_HI = WIN_LO + 25'(WIN_SIZE);

  state_e      state_q, state_d;
  logic        mem_ready_q, mem_ready_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        rom_valid_q, rom_valid_d;
  logic [23:0] rom_addr_q, rom_addr_d;

  logic [23:0]      req_word_s;
  logic             req_in_win_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic             hit_s;
  logic             unused_ok_s;

  logic [IDX_W-1:0] rd_idx_s;
  logic             rd_valid_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [31:0]      rd_data_s;
  logic             wr_en_s;

  assign req_word_s   = {mem_addr[23:2], 2'b00};
  assign req_in_win_s = ({1'b0, req_word_s} >= WIN_LO) && ({1'b0, req_word_s} < WIN_HI);
  assign req_idx_s    = mem_addr[2 +: IDX_W];
  assign req_tag_s    = mem_addr[23 -: TAG_W];
  assign unused_ok_s  = &{1'b0, mem_addr[1:0]};

`ifdef ROM_PREFETCH_EN
  logic [24:0] next_word_s;
  logic        next_in_win_s;
  logic        next_cached_s;

  // While filling, the read port looks at the next word's line to decide on a prefetch.
  assign next_word_s   = {1'b0, rom_addr_q} + 25'd4;
  assign next_in_win_s = next_word_s < WIN_HI;
  assign next_cached_s = rd_valid_s && (rd_tag_s == next_word_s[23 -: TAG_W]);
  assign rd_idx_s      = (state_q == ST_IDLE) ? req_idx_s : next_word_s[2 +: IDX_W];
`else
  assign rd_idx_s = req_idx_s;
`endif

  assign hit_s = rd_valid_s && (rd_tag_s == req_tag_s);

  rom_cache_lines #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk        (clk),
    .reset      (reset),
    .flush_i    (flush),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (rom_addr_q[2 +: IDX_W]),
    .wr_tag_i   (rom_addr_q[23 -: TAG_W]),
    .wr_data_i  (rom_rdata),
    .rd_idx_i   (rd_idx_s),
    .rd_valid_o (rd_valid_s),
    .rd_tag_o   (rd_tag_s),
    .rd_data_o  (rd_data_s)
  );

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    rom_valid_d = rom_valid_q;
    rom_addr_d  = rom_addr_q;
    wr_en_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // mem_ready_q blocks re-accepting the request still held during its ready cycle.
        if (mem_valid && !mem_ready_q) begin
          if (!req_in_win_s) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = 32'h0000_0000;
          end else if (hit_s) begin
            mem_ready_d = 1'b1;
            mem_rdata_d = rd_data_s;
          end else begin
            rom_valid_d = 1'b1;
            rom_addr_d  = req_word_s;
            state_d     = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (rom_ready) begin
          rom_valid_d = 1'b0;
          wr_en_s     = 1'b1;
          mem_rdata_d = rom_rdata;
          mem_ready_d = 1'b1;
          state_d     = ST_IDLE;
`ifdef ROM_PREFETCH_EN
          if (next_in_win_s && !next_cached_s) begin
            state_d = ST_PREFETCH;
          end
`endif
        end
      end
`ifdef ROM_PREFETCH_EN
      ST_PREFETCH: begin
        // First cycle is a bubble so rom_valid visibly drops between the two requests.
        if (!rom_valid_q) begin
          rom_valid_d = 1'b1;
          rom_addr_d  = next_word_s[23:0];
        end else if (rom_ready) begin
          rom_valid_d = 1'b0;
          wr_en_s     = 1'b1;
          state_d     = ST_IDLE;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0000_0000;
      rom_valid_q <= 1'b0;
      rom_addr_q  <= 24'h00_0000;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      rom_valid_q <= rom_valid_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign rom_valid = rom_valid_q;
  assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_rom_fetch_cache.sv
// Self-checking bench for rom_fetch_cache: directed vector table, hand-written corner
// sequences and a randomized run against a line-level cache model; stub ROM returns ~addr.
module tb_rom_fetch_cache;

`ifdef ROM_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif
  localparam int LINES = 16;
  localparam int NV    = 13;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        flush_main;
  logic        flush_stub;
  logic        flush_s;
  logic        rom_valid;
  logic [23:0] rom_addr;
  logic        rom_ready;
  logic [31:0] rom_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rom_delay = 3;
  int stale_req_cnt = 0;
  int flush_req_cnt = 0;
  logic [23:0] fetch_q[$];

  bit m_valid [LINES];
  int unsigned m_tag [LINES];

  typedef struct {
    logic [23:0] addr;
    int          delay;
    bit          flush;
    logic [31:0] data;
    int          lat;
    int          nf;
  } vec_t;
  vec_t vt [NV];

  assign flush_s = flush_main | flush_stub;

  rom_fetch_cache dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .flush     (flush_s),
    .rom_valid (rom_valid),
    .rom_addr  (rom_addr),
    .rom_ready (rom_ready),
    .rom_rdata (rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_flush();
    flush_main = 1'b1;
    idle(1);
    flush_main = 1'b0;
    idle(1);
  endtask

  // CPU side: hold mem_valid through the ready cycle, as the real core does.
  task automatic cpu_read(input logic [23:0] a, output logic [31:0] d, output int lat);
    mem_valid = 1'b1;
    mem_addr  = a;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!mem_ready && lat < 200);
    d = mem_rdata;
    if (!mem_ready) check("read_timeout", 32'(lat), 32'd0);
    @(posedge clk);
    #1;
    check("no_reserve", {31'd0, mem_ready}, 32'd0);
    mem_valid = 1'b0;
  endtask

  // Stub ROM: answers each request rom_delay cycles after rom_valid first appears.
  initial begin : rom_stub
    int cnt;
    bit busy;
    bit prev_ready;
    int stale_done;
    int flush_done;
    logic [23:0] cur;
    cnt = 0; busy = 1'b0; prev_ready = 1'b0; stale_done = 0; flush_done = 0; cur = '0;
    rom_ready = 1'b0; rom_rdata = 32'h0; flush_stub = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rom_ready  = 1'b0;
      flush_stub = 1'b0;
      if (prev_ready && !reset) check("rom_valid_drop", {31'd0, rom_valid}, 32'd0);
      prev_ready = 1'b0;
      if (!rom_valid) begin
        busy = 1'b0;
        if (stale_done != stale_req_cnt) begin
          stale_done = stale_req_cnt;
          rom_ready  = 1'b1;
          rom_rdata  = 32'hDEAD_BEEF;
        end
      end else if (!busy) begin
        busy = 1'b1;
        cnt  = 0;
        cur  = rom_addr;
        fetch_q.push_back(rom_addr);
      end else begin
        check("rom_addr_stable", {8'd0, rom_addr}, {8'd0, cur});
        cnt++;
        if (cnt >= rom_delay) begin
          rom_ready  = 1'b1;
          rom_rdata  = ~{8'h00, cur};
          busy       = 1'b0;
          prev_ready = 1'b1;
          if (flush_done != flush_req_cnt) begin
            flush_done = flush_req_cnt;
            flush_stub = 1'b1;
          end
        end
      end
    end
  end

  function automatic bit in_win(input int unsigned w);
    return (w >= 32'h0010_0000) && (w < 32'h0010_2000);
  endfunction

  function automatic bit present(input int unsigned w);
    int unsigned i;
    i = (w / 4) % LINES;
    return m_valid[i] && (m_tag[i] == (w / 4) / LINES);
  endfunction

  task automatic install(input int unsigned w);
    m_valid[(w / 4) % LINES] = 1'b1;
    m_tag[(w / 4) % LINES]   = (w / 4) / LINES;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_read(input logic [23:0] a, input int d,
                            output logic [31:0] data, output int lat, output int nf);
    int unsigned w;
    w = {8'd0, a[23:2], 2'b00};
    if (!in_win(w)) begin
      data = 32'h0; lat = 1; nf = 0;
    end else if (present(w)) begin
      data = ~w; lat = 1; nf = 0;
    end else begin
      install(w);
      data = ~w; lat = d + 2; nf = 1;
      if (PF != 0 && in_win(w + 4) && !present(w + 4)) begin
        install(w + 4);
        nf = 2;
      end
    end
  endtask

  initial begin : main
    logic [31:0] rd, exp_d;
    logic [23:0] a;
    int lat, exp_lat, n0, nf, exp_nf, d, r;

    reset = 1'b1; mem_valid = 1'b0; mem_addr = 24'h0; flush_main = 1'b0;
    idle(3);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_rom_valid", {31'd0, rom_valid}, 32'd0);
    check("rst_rom_addr", {8'd0, rom_addr}, 32'd0);
    reset = 1'b0;
    idle(2);

    // Reset in the middle of a fill aborts the downstream request.
    mem_valid = 1'b1; mem_addr = 24'h100200;
    idle(2);
    check("midfill_rom_valid", {31'd0, rom_valid}, 32'd1);
    reset = 1'b1; mem_valid = 1'b0;
    #1;
    check("midfill_abort", {31'd0, rom_valid}, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // A stray completion in IDLE must be ignored.
    stale_req_cnt++;
    idle(3);
    check("stale_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("stale_rom_valid", {31'd0, rom_valid}, 32'd0);
    check("stale_mem_rdata", mem_rdata, 32'd0);

    vt[0]  = '{24'h100010, 3, 1'b0, 32'hFFEF_FFEF, 5, 1 + PF};
    vt[1]  = '{24'h100010, 3, 1'b0, 32'hFFEF_FFEF, 1, 0};
    vt[2]  = '{24'h100050, 6, 1'b0, 32'hFFEF_FFAF, 8, 1 + PF};
    vt[3]  = '{24'h100010, 3, 1'b0, 32'hFFEF_FFEF, 5, 1 + PF};
    vt[4]  = '{24'h000100, 3, 1'b0, 32'h0000_0000, 1, 0};
    vt[5]  = '{24'h100010, 3, 1'b1, 32'hFFEF_FFEF, 5, 1 + PF};
    vt[6]  = '{24'h100014, 3, 1'b0, 32'hFFEF_FFEB, (PF != 0) ? 1 : 5, 1 - PF};
    vt[7]  = '{24'h101FFC, 3, 1'b0, 32'hFFEF_E003, 5, 1};
    vt[8]  = '{24'h101FF8, 2, 1'b0, 32'hFFEF_E007, 4, 1};
    vt[9]  = '{24'h0FFFFC, 3, 1'b0, 32'h0000_0000, 1, 0};
    vt[10] = '{24'h102000, 3, 1'b0, 32'h0000_0000, 1, 0};
    vt[11] = '{24'h100000, 1, 1'b0, 32'hFFEF_FFFF, 3, 1 + PF};
    vt[12] = '{24'h100003, 3, 1'b0, 32'hFFEF_FFFF, 1, 0};

    for (int i = 0; i < NV; i++) begin
      if (vt[i].flush) pulse_flush();
      rom_delay = vt[i].delay;
      n0 = fetch_q.size();
      cpu_read(vt[i].addr, rd, lat);
      idle(vt[i].delay + 6);
      nf = fetch_q.size() - n0;
      check($sformatf("vec%0d_data", i), rd, vt[i].data);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      check($sformatf("vec%0d_fetches", i), 32'(nf), 32'(vt[i].nf));
      if (nf >= 1) check($sformatf("vec%0d_addr", i), {8'd0, fetch_q[n0]}, {8'd0, vt[i].addr[23:2], 2'b00});
      if (nf >= 2) check($sformatf("vec%0d_pf_addr", i), {8'd0, fetch_q[n0 + 1]}, {8'd0, vt[i].addr[23:2], 2'b00} + 32'd4);
    end

    // Flush in the same cycle as the fill completion: data returned, line not kept.
    rom_delay = 3;
    flush_req_cnt++;
    cpu_read(24'h100100, rd, lat);
    idle(10);
    check("flushfill_data", rd, 32'hFFEF_FEFF);
    n0 = fetch_q.size();
    cpu_read(24'h100100, rd, lat);
    idle(10);
    check("flushfill_reread_lat", 32'(lat), 32'd5);
    check("flushfill_reread_fetches", 32'(fetch_q.size() - n0), 32'd1);
    check("flushfill_reread_data", rd, 32'hFFEF_FEFF);

    pulse_flush();
    model_clear();
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_flush();
        model_clear();
      end
      r = int'($urandom_range(0, 99));
      if (r < 8)       a = 24'($urandom_range(0, 32'h000F_FFFF));
      else if (r < 15) a = 24'($urandom_range(32'h0010_2000, 32'h00FF_FFFF));
      else if (r < 30) a = 24'h101F00 + 24'($urandom_range(0, 255));
      else             a = 24'h100000 + 24'($urandom_range(0, 127));
      d = int'($urandom_range(1, 5));
      rom_delay = d;
      model_read(a, d, exp_d, exp_lat, exp_nf);
      n0 = fetch_q.size();
      cpu_read(a, rd, lat);
      idle(d + 6);
      check($sformatf("rnd%0d_data_%h", k, a), rd, exp_d);
      check($sformatf("rnd%0d_lat_%h", k, a), 32'(lat), 32'(exp_lat));
      check($sformatf("rnd%0d_fetches_%h", k, a), 32'(fetch_q.size() - n0), 32'(exp_nf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
